switch_sequencer: RTL
=====================

# switch_sequencer

Sequencer that steps the photonic-switch core through a queue of W setpoints. Host writes 13-bit W words into a small FIFO. For each word the block drives the W bus, pulses the decoder's trigger, and waits for the decoder's done. It then enables the PWM generator for a programmed dwell counted in 1 MHz ticks, and advances to the next word. It sits between the host/load interface and the existing decoder plus PWM datapath, replacing direct host control of their reset and enable.

## Interface
- DEPTH, 4: FIFO depth in W words; power of two, 2..16.
- W_WIDTH, 13: setpoint width.
- DWELL_WIDTH, 16: dwell counter width.
- DEC_TIMEOUT, 64: max clk cycles to wait for decoder done.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high.
- wr_valid  in  1  host presents a W word.
- wr_W  in  W_WIDTH  word to enqueue.
- wr_ready  out  1  FIFO not full; a write occurs when wr_valid && wr_ready.
- start  in  1  level; while high the sequencer consumes the queue.
- abort  in  1  single-cycle; ends the current step, flushes FIFO.
- dwell  in  DWELL_WIDTH  tick_1MHz ticks per step; sampled at LOAD.
- tick_1MHz  in  1  1 MHz toggle-enable, one clk wide.
- dec_W  out  W_WIDTH  W bus to decoder.
- dec_trig  out  1  one-cycle decoder reset/trigger pulse.
- dec_done  in  1  decoder done.
- pwm_en  out  1  PWM generator enable.
- step_done  out  1  one-cycle pulse per completed step.
- busy  out  1  state != IDLE.
- err  out  1  sticky decoder-timeout flag.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- States: IDLE, LOAD, TRIG, WAIT, RUN, ERR.
- IDLE -> LOAD when start && count != 0.
- LOAD:
  - pop FIFO head into dec_W register;
  - latch dwell (0 treated as 1);
  - -> TRIG.
- TRIG:
  - dec_trig = 1 for exactly one cycle;
  - clear timeout counter;
  - -> WAIT.
- WAIT:
  - ignore dec_done on the first WAIT cycle, because the decoder's done is stale;
  - from the second cycle, dec_done = 1 -> RUN;
  - timeout counter reaching DEC_TIMEOUT -> ERR.
- RUN:
  - pwm_en = 1;
  - dwell counter decrements on each tick_1MHz;
  - at 0: step_done pulse, pwm_en drops;
  - then -> LOAD if start && count != 0, else -> IDLE.
- ERR:
  - set err, pwm_en = 0, flush FIFO;
  - -> IDLE; err stays set until reset.
- abort in any non-IDLE state:
  - -> IDLE next cycle;
  - pwm_en = 0 that cycle;
  - FIFO flushed;
  - no step_done.
- start deasserted mid-RUN: the current step finishes, then the block goes to IDLE.
- FIFO:
  - write to a full FIFO is refused, because wr_ready = 0;
  - a simultaneous write and pop in LOAD is legal and leaves count unchanged;
  - pointers wrap modulo DEPTH;
  - a write in the same cycle as abort or the ERR flush is dropped.
- dec_W holds its last loaded value in IDLE, so the PWM values stay stable.

## Timing
- Reset values:
  - state IDLE, count 0, wr_ready 1;
  - dec_W 0;
  - dec_trig, pwm_en, step_done, busy, err all 0.
- All outputs are registered.
- busy rises the cycle after start is seen with count != 0.
- Write to first dec_trig: a write at cycle n, with start high, gives count = 1 at n+1, LOAD at n+2, and dec_trig at n+3.
- pwm_en asserts the cycle after dec_done is sampled in WAIT.
- RUN lasts exactly dwell tick_1MHz pulses.
- pwm_en falls in the same cycle step_done pulses.
- Back-to-back steps: pwm_en is low for at least 3 cycles (LOAD, TRIG, WAIT) between steps.
- Asynchronous reset mid-step forces all outputs to reset values immediately; the FIFO contents are lost.

## Structure
- Package switch_seq_pkg holds:
  - state enum (IDLE, LOAD, TRIG, WAIT, RUN, ERR);
  - default W_WIDTH and DWELL_WIDTH constants.
- Sub-module seq_fifo:
  - parameterised synchronous FIFO;
  - ports: push, pop, flush, full, empty, count.
- The top module holds the FSM, the dwell counter and the timeout counter.

## Test plan
- Single step: write W=0x0A5 with dwell=3 and start=1, decoder model returns done 5 cycles after trig -> dec_W=0x0A5, one dec_trig pulse, pwm_en high for exactly 3 ticks, one step_done, busy then low.
- Queue of 4: write 0x001, 0x002, 0x003, 0x004 (wr_ready low on a 5th write at DEPTH=4) -> four steps in order, count 4→0, four step_done pulses.
- Timeout: decoder model never raises done -> after 64 WAIT cycles err=1, pwm_en stays 0, count=0, state IDLE.
- Abort mid-RUN with 2 words queued -> pwm_en low next cycle, count=0, no step_done.
- Stale done: dec_done held at 1 continuously -> RUN entered no earlier than the second WAIT cycle.
- Async reset asserted during RUN -> all outputs at reset values in the same cycle, err=0, count=0.

Source files
------------

// File: rtl/switch_seq_pkg.sv
// -----------------------------------------------------------------------------
// switch_seq_pkg
// Shared definitions for the photonic-switch setpoint sequencer:
//   - seq_state_t : sequencer FSM state encoding
//   - DEF_W_WIDTH / DEF_DWELL_WIDTH : default setpoint and dwell widths
// -----------------------------------------------------------------------------
package switch_seq_pkg;

    localparam int DEF_W_WIDTH     = 13;
    localparam int DEF_DWELL_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        TRIG = 3'd2,
        WAIT = 3'd3,
        RUN  = 3'd4,
        ERR  = 3'd5
    } seq_state_t;

endpackage : switch_seq_pkg

// File: rtl/seq_fifo.sv
// -----------------------------------------------------------------------------
// seq_fifo
// Small synchronous FIFO holding queued W setpoints.
// Ports:
//   clk, reset        : core clock, asynchronous active-high reset
//   push, din         : enqueue din (ignored when full or flushing)
//   pop, dout         : dequeue; dout always shows the current head
//   flush             : discard all entries; wins over push and pop
//   full, empty       : registered status flags
//   count             : registered occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// -----------------------------------------------------------------------------
module seq_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 13,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CW-1:0]    count_nxt;

    assign do_push = push && !full  && !flush;
    assign do_pop  = pop  && !empty && !flush;
    assign dout    = mem[rd_ptr];

    // NOTE: every signal driven in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (!do_push && do_pop)
            count_nxt = count - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
            empty <= (count_nxt == '0);
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately left out of reset; the pointers and count
    // define which entries are valid, so clearing the array buys nothing.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule : seq_fifo

// File: rtl/switch_sequencer.sv
// -----------------------------------------------------------------------------
// switch_sequencer
// Steps the photonic-switch core through a queue of W setpoints. Each queued
// word is driven onto dec_W, the decoder is triggered, and once it reports
// done the PWM generator is enabled for 'dwell' tick_1MHz periods.
// Ports:
//   clk, reset          : core clock, asynchronous active-high reset
//   wr_valid/wr_W/wr_ready : host write into the setpoint FIFO
//   start               : level; sequencer consumes the queue while high
//   abort               : one-cycle pulse; ends the step and flushes the FIFO
//   dwell               : ticks per step, sampled at LOAD (0 acts as 1)
//   tick_1MHz           : one-clk-wide 1 MHz enable
//   dec_W, dec_trig     : decoder setpoint bus and one-cycle trigger
//   dec_done            : decoder completion
//   pwm_en              : PWM generator enable
//   step_done           : one-cycle pulse per completed step
//   busy, err, count    : status (err is sticky until reset)
// All outputs except wr_ready come straight from flops; wr_ready is the
// inverse of the FIFO's registered full flag.
// -----------------------------------------------------------------------------
module switch_sequencer
    import switch_seq_pkg::*;
#(
    parameter  int DEPTH       = 4,
    parameter  int W_WIDTH     = DEF_W_WIDTH,
    parameter  int DWELL_WIDTH = DEF_DWELL_WIDTH,
    parameter  int DEC_TIMEOUT = 64,
    localparam int CW          = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [W_WIDTH-1:0]     wr_W,
    output logic                   wr_ready,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic                   tick_1MHz,
    output logic [W_WIDTH-1:0]     dec_W,
    output logic                   dec_trig,
    input  logic                   dec_done,
    output logic                   pwm_en,
    output logic                   step_done,
    output logic                   busy,
    output logic                   err,
    output logic [CW-1:0]          count
);

    localparam int TW = $clog2(DEC_TIMEOUT + 1);

    seq_state_t             state;
    seq_state_t             next_state;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [TW-1:0]          to_cnt;
    logic                   step_fin;

    logic                   abort_hit;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_flush;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [W_WIDTH-1:0]     fifo_head;

    // abort only matters while a step is in progress; in IDLE it is ignored.
    assign abort_hit  = abort && (state != IDLE);
    assign fifo_flush = abort_hit || (state == ERR);
    assign fifo_pop   = (state == LOAD) && !abort_hit;
    // The FIFO itself drops a push that coincides with a flush.
    assign fifo_push  = wr_valid && wr_ready;
    assign wr_ready   = !fifo_full;

    seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (wr_W),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .flush (fifo_flush),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (count)
    );

    always_comb begin
        next_state = state;
        step_fin   = 1'b0;
        if (abort_hit) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: if (start && !fifo_empty) next_state = LOAD;
                LOAD: next_state = TRIG;
                TRIG: next_state = WAIT;
                WAIT: begin
                    // to_cnt == 0 marks the first WAIT cycle, where dec_done
                    // still reflects the previous conversion.
                    if (dec_done && (to_cnt != '0))
                        next_state = RUN;
                    else if (to_cnt == TW'(DEC_TIMEOUT - 1))
                        next_state = ERR;
                end
                RUN: begin
                    if (tick_1MHz && (dwell_cnt == DWELL_WIDTH'(1))) begin
                        step_fin   = 1'b1;
                        next_state = (start && !fifo_empty) ? LOAD : IDLE;
                    end
                end
                ERR:     next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Outputs are decoded from next_state so they line up with the state
    // they describe while still coming from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            dec_trig  <= 1'b0;
            pwm_en    <= 1'b0;
            step_done <= 1'b0;
            err       <= 1'b0;
            dec_W     <= '0;
            dwell_cnt <= '0;
            to_cnt    <= '0;
        end else begin
            state     <= next_state;
            busy      <= (next_state != IDLE);
            dec_trig  <= (next_state == TRIG);
            pwm_en    <= (next_state == RUN);
            step_done <= step_fin;
            err       <= err || (next_state == ERR);

            if (fifo_pop) begin
                dec_W     <= fifo_head;
                dwell_cnt <= (dwell == '0) ? DWELL_WIDTH'(1) : dwell;
            end else if ((state == RUN) && tick_1MHz) begin
                dwell_cnt <= dwell_cnt - 1'b1;
            end

            if (state == TRIG)
                to_cnt <= '0;
            else if (state == WAIT)
                to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule : switch_sequencer
